// File: rtl/fb_pkg.sv
// Shared constants and elaboration helpers for the frame-buffer pixel streamer.
package fb_pkg;

   localparam int unsigned DEF_WORD_W     = 32;
   localparam int unsigned DEF_PIX_W      = 8;
   localparam int unsigned DEF_FIFO_DEPTH = 8;

   // Ceiling log2 for elaboration-time sizing
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((64'd1 << result) < 64'(value)) result++;
      return result;
   endfunction

   // Lane index width, kept at least one bit wide
   function automatic int unsigned lane_w(input int unsigned ppw);
      return (ppw > 1) ? clog2(ppw) : 1;
   endfunction

   localparam int unsigned PIX_PER_WORD = DEF_WORD_W / DEF_PIX_W;
   localparam int unsigned LANE_W       = lane_w(PIX_PER_WORD);
   localparam int unsigned LVL_W        = clog2(DEF_FIFO_DEPTH) + 1;

endpackage

// File: rtl/fb_word_fifo.sv
// Synchronous show-ahead word FIFO with flush; holds prefetched frame RAM words.
module fb_word_fifo
   import fb_pkg::*;
#(
   parameter int unsigned WORD_W  = DEF_WORD_W,
   parameter int unsigned DEPTH   = DEF_FIFO_DEPTH,
   parameter int unsigned LEVEL_W = LVL_W
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               flush,
   input  logic               push,
   input  logic               pop,
   input  logic [WORD_W-1:0]  din,
   output logic [WORD_W-1:0]  dout,
   output logic [LEVEL_W-1:0] level
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

   logic [WORD_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign do_pop  = pop && (level != '0);
   assign do_push = push && (level < LEVEL_W'(DEPTH));
   assign dout    = mem[rd_ptr];

   // Storage array: written on accepted push only
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

   // Pointers and occupancy; flush empties the FIFO
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         level <= level + LEVEL_W'(do_push) - LEVEL_W'(do_pop);
      end
   end

endmodule

// File: rtl/fb_pixel_streamer.sv
// Frame-buffer read engine: prefetches RAM words into a FIFO and unpacks them
// LSB lane first into one pixel per pix_req. Optional underrun counter is
// enabled by defining FB_UNDERRUN_CNT_EN.
module fb_pixel_streamer
   import fb_pkg::*;
#(
   parameter int unsigned      WORD_W       = 32,
   parameter int unsigned      PIX_W        = 8,
   parameter int unsigned      ADDR_W       = 17,
   parameter int unsigned      FRAME_WORDS  = 76800,
   parameter int unsigned      RAM_LAT      = 1,
   parameter int unsigned      FIFO_DEPTH   = 8,
   parameter logic [PIX_W-1:0] UNDERRUN_PIX = '0
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        frame_start,
   input  logic                        pix_req,
   output logic [PIX_W-1:0]            pix_data,
   output logic                        pix_valid,
   output logic                        ram_rd_en,
   output logic [ADDR_W-1:0]           ram_addr,
   input  logic [WORD_W-1:0]           ram_rdata,
   output logic [clog2(FIFO_DEPTH):0]  fifo_level,
   output logic                        underrun
`ifdef FB_UNDERRUN_CNT_EN
   ,
   output logic [15:0]                 underrun_cnt
`endif
);

   localparam int unsigned NPIX       = WORD_W / PIX_W;
   localparam int unsigned LANE_BITS  = lane_w(NPIX);
   localparam int unsigned LEVEL_BITS = clog2(FIFO_DEPTH) + 1;
   localparam int unsigned SUM_BITS   = LEVEL_BITS + 1;

   logic                       rd_en_q;
   logic [ADDR_W-1:0]          addr_q;
   logic [RAM_LAT-1:0]         pipe_q;
   logic [LEVEL_BITS-1:0]      infl_q;
   logic [LEVEL_BITS-1:0]      drain_q;
   logic [LANE_BITS-1:0]       lane_q;

   logic [WORD_W-1:0]          head_word;
   logic [NPIX-1:0][PIX_W-1:0] head_lanes;

   logic                       ret_c;
   logic                       push_c;
   logic                       pop_c;
   logic                       serve_c;
   logic                       empty_c;
   logic                       lane_last_c;
   logic [LEVEL_BITS-1:0]      infl_nx_c;
   logic [LEVEL_BITS-1:0]      drain_nx_c;
   logic [LEVEL_BITS-1:0]      level_nx_c;
   logic                       rd_en_nx_c;

   assign ram_rd_en  = rd_en_q;
   assign ram_addr   = addr_q;
   assign head_lanes = head_word;

   fb_word_fifo #(
      .WORD_W  (WORD_W),
      .DEPTH   (FIFO_DEPTH),
      .LEVEL_W (LEVEL_BITS)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (frame_start),
      .push    (push_c),
      .pop     (pop_c),
      .din     (ram_rdata),
      .dout    (head_word),
      .level   (fifo_level)
   );

   // Fetch gate, drain accounting and unpack handshake for this cycle
   always_comb begin
      ret_c       = pipe_q[RAM_LAT-1];
      push_c      = 1'b0;
      pop_c       = 1'b0;
      serve_c     = pix_req && !frame_start;
      empty_c     = (fifo_level == '0);
      lane_last_c = (lane_q == LANE_BITS'(NPIX - 1));
      infl_nx_c   = infl_q + LEVEL_BITS'(rd_en_q) - LEVEL_BITS'(ret_c);
      drain_nx_c  = drain_q;
      level_nx_c  = fifo_level;

      // Returning words are dropped while a post-frame_start drain is pending
      push_c = ret_c && (drain_q == '0) && !frame_start;
      pop_c  = serve_c && !empty_c && lane_last_c;

      if (frame_start) begin
         drain_nx_c = infl_nx_c;
         level_nx_c = '0;
      end else begin
         if (ret_c && (drain_q != '0)) drain_nx_c = drain_q - LEVEL_BITS'(1);
         level_nx_c = fifo_level + LEVEL_BITS'(push_c) - LEVEL_BITS'(pop_c);
      end

      rd_en_nx_c = (drain_nx_c == '0) &&
                   ((SUM_BITS'(level_nx_c) + SUM_BITS'(infl_nx_c)) < SUM_BITS'(FIFO_DEPTH));
   end

   // Read strobe, wrapping word address, return-marker pipe and counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_en_q <= 1'b0;
         addr_q  <= '0;
         pipe_q  <= '0;
         infl_q  <= '0;
         drain_q <= '0;
      end else begin
         rd_en_q   <= rd_en_nx_c;
         infl_q    <= infl_nx_c;
         drain_q   <= drain_nx_c;
         pipe_q[0] <= rd_en_q;
         for (int i = 1; i < int'(RAM_LAT); i++) pipe_q[i] <= pipe_q[i-1];
         if (frame_start) begin
            addr_q <= '0;
         end else if (rd_en_q) begin
            addr_q <= (addr_q == ADDR_W'(FRAME_WORDS - 1)) ? '0 : addr_q + ADDR_W'(1);
         end
      end
   end

   // Lane unpack; the lane advances on underrun to keep raster phase
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lane_q    <= '0;
         pix_data  <= '0;
         pix_valid <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         pix_valid <= serve_c;
         if (frame_start) begin
            lane_q   <= '0;
            underrun <= 1'b0;
         end else if (serve_c) begin
            lane_q <= lane_last_c ? '0 : lane_q + LANE_BITS'(1);
            if (empty_c) begin
               pix_data <= UNDERRUN_PIX;
               underrun <= 1'b1;
            end else begin
               pix_data <= head_lanes[lane_q];
            end
         end
      end
   end

`ifdef FB_UNDERRUN_CNT_EN
   // Saturating count of underrun pixels, cleared only by reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         underrun_cnt <= '0;
      end else if (serve_c && empty_c && (underrun_cnt != 16'hFFFF)) begin
         underrun_cnt <= underrun_cnt + 16'd1;
      end
   end
`endif

endmodule
